// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM states
// and the address fault check reused by future responders.
package dmem_responder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // A byte address faults when it is not word aligned or its word index lies
  // beyond the backing storage.
  function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                      input int unsigned       depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// Synchronous single-port word array with write enable and registered read.
module dmem_storage
  import dmem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the data-memory interface: one outstanding load/store,
// fixed access latency, valid/ready request and response channels.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_error_q, resp_error_d;
  logic              rd_ok_q, rd_ok_d;
  logic              busy_q, busy_d;

  logic              enter_resp;
  logic              ent_write;
  logic [WORD_W-1:0] ent_addr;
  logic [WORD_W-1:0] ent_wdata;
  logic              ent_err;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;

  // With LATENCY==1 the RESP-entry edge is the accepting edge itself, so the
  // access operands come straight from the request port instead of the
  // capture registers.
  always_comb begin
    if (state_q == IDLE) begin
      ent_write = req_write;
      ent_addr  = req_addr;
      ent_wdata = req_wdata;
    end else begin
      ent_write = write_q;
      ent_addr  = addr_q;
      ent_wdata = wdata_q;
    end
    ent_err = addr_fault(ent_addr, DEPTH_WORDS);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    rd_ok_d      = rd_ok_q;
    enter_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
          end else begin
            state_d     = WAIT;
            cnt_d       = CW'(LATENCY - 1);
            req_ready_d = 1'b0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) enter_resp = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d      = RESP;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b1;
      resp_error_d = ent_err;
      rd_ok_d      = !ent_write && !ent_err;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      rd_ok_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      rd_ok_q      <= rd_ok_d;
      busy_q       <= busy_d;
    end
  end

  // Reset must win over a store committing on the same edge.
  assign mem_we = enter_resp && ent_write && !ent_err && !reset;
  assign mem_re = enter_resp && !ent_write && !ent_err;

  dmem_storage #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_storage (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (ent_addr[AW+1:2]),
    .wdata(ent_wdata),
    .rdata(mem_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = rd_ok_q ? mem_rdata : '0;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 instance (a) and a
// LATENCY=1 instance (b) sharing clock, reset and request payload.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        va, vb;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        rdy_a, rv_a, err_a, busy_a;
  logic [31:0] rd_a;
  logic        rdy_b, rv_b, err_b, busy_b;
  logic [31:0] rd_b;

  int tests = 0;
  int fails = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(va), .req_ready(rdy_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_ready(resp_ready), .resp_rdata(rd_a),
    .resp_error(err_a), .busy(busy_a)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rdy_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_ready(resp_ready), .resp_rdata(rd_b),
    .resp_error(err_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction with resp_ready high; exp_wait is the number of
  // edges after the accepting edge before resp_valid is seen.
  task automatic xact(input bit sel, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int exp_wait,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int n;
    chk({tag, ".req_ready"}, sel ? rdy_b : rdy_a, 1'b1);
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = 1'b1;
    if (sel) vb = 1'b1; else va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    req_write = ~wr; req_addr = ~a; req_wdata = ~d;
    n = 0;
    while (!(sel ? rv_b : rv_a) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, exp_wait);
    chk({tag, ".rdata"}, sel ? rd_b : rd_a, exp_rd);
    chk({tag, ".error"}, sel ? err_b : err_a, exp_err);
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, sel ? rv_b : rv_a, 1'b0);
    chk({tag, ".ready_back"}, sel ? rdy_b : rdy_a, 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; va = 1'b0; vb = 1'b0; resp_ready = 1'b1;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", rdy_a, 1'b1);
    chk("rst.resp_valid", rv_a, 1'b0);
    chk("rst.resp_rdata", rd_a, 32'h0);
    chk("rst.resp_error", err_a, 1'b0);
    chk("rst.busy", busy_a, 1'b0);
    chk("rst.b_req_ready", rdy_b, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    xact(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 3, 32'h0, 1'b0, "st40");
    xact(1'b0, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0, "ld40");

    // Backpressure, with a request held pending the whole time.
    resp_ready = 1'b0; req_write = 1'b0; req_addr = 32'h40; va = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h44;
    chk("bp.busy", busy_a, 1'b1);
    n = 0;
    while (!rv_a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp.latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp.valid_hold", rv_a, 1'b1);
      chk("bp.rdata_hold", rd_a, 32'hDEADBEEF);
      chk("bp.req_ready_low", rdy_a, 1'b0);
    end
    va = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.valid_drop", rv_a, 1'b0);
    chk("bp.req_ready", rdy_a, 1'b1);
    chk("bp.busy_idle", busy_a, 1'b0);

    xact(1'b0, 1'b1, 32'h42, 32'h12345678, 3, 32'h0, 1'b1, "st42_misal");
    xact(1'b0, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0, "ld40_after_misal");

    xact(1'b0, 1'b0, 32'h1000, 32'h0, 3, 32'h0, 1'b1, "ld1000_oor");
    xact(1'b0, 1'b1, 32'h1000, 32'hBAADF00D, 3, 32'h0, 1'b1, "st1000_oor");
    xact(1'b0, 1'b1, 32'hFFC, 32'h11223344, 3, 32'h0, 1'b0, "stFFC");
    xact(1'b0, 1'b0, 32'hFFC, 32'h0, 3, 32'h11223344, 1'b0, "ldFFC");
    xact(1'b0, 1'b0, 32'h0, 32'h0, 3, 32'h0, 1'b0, "ld0_no_alias");

    // Reset while waiting drops the store.
    xact(1'b0, 1'b1, 32'h80, 32'h0, 3, 32'h0, 1'b0, "st80_zero");
    req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'hCAFEF00D; va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    chk("rwait.busy", busy_a, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rwait.req_ready", rdy_a, 1'b1);
    chk("rwait.resp_valid", rv_a, 1'b0);
    chk("rwait.busy", busy_a, 1'b0);
    xact(1'b0, 1'b0, 32'h80, 32'h0, 3, 32'h0, 1'b0, "ld80_after_rwait");

    // Reset on the very edge that would enter RESP and commit the store.
    req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'hCAFEF00D; va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("redge.still_wait", rv_a, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("redge.resp_valid", rv_a, 1'b0);
    chk("redge.req_ready", rdy_a, 1'b1);
    xact(1'b0, 1'b0, 32'h80, 32'h0, 3, 32'h0, 1'b0, "ld80_after_redge");

    xact(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 0, 32'h0, 1'b0, "L1.st8");
    xact(1'b1, 1'b0, 32'h8, 32'h0, 0, 32'h5A5A5A5A, 1'b0, "L1.ld8");
    xact(1'b1, 1'b0, 32'h9, 32'h0, 0, 32'h0, 1'b1, "L1.ld9_misal");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
